// File: rtl/dz_matrix_scan_if.sv
// dz_matrix_scan_if: host-side bundle of the bicolour matrix scanner.
// Carries back-buffer writes, swap handshake, frame status and matrix pins.
interface dz_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int RW   = $clog2(ROWS)
);
    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_colr;
    logic [COLS-1:0] wr_colg;
    logic            swap_req;
    logic            swap_pend;
    logic            swap_done;
    logic            frame_tick;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] colr;
    logic [COLS-1:0] colg;

    modport master (
        output wr_en, wr_row, wr_colr, wr_colg, swap_req,
        input  swap_pend, swap_done, frame_tick, row, colr, colg
    );

    modport slave (
        input  wr_en, wr_row, wr_colr, wr_colg, swap_req,
        output swap_pend, swap_done, frame_tick, row, colr, colg
    );
endinterface

// File: rtl/dz_matrix_scan.sv
// dz_matrix_scan: double-buffered bicolour LED matrix row scanner.
// Ports: clk, rst (async, active-high), bus (slave: writes, swap, pins).
// Optional DZ_BLINK_EN adds input blink and parameter BLINK_FRAMES.
module dz_matrix_scan #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int DWELL = 4,
    parameter int RW    = $clog2(ROWS)
`ifdef DZ_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 16
`endif
) (
    input logic clk,
    input logic rst,
`ifdef DZ_BLINK_EN
    input logic blink,
`endif
    dz_matrix_scan_if.slave bus
);
    localparam int AW = $clog2(ROWS);
    localparam int DW = $clog2(DWELL);
    localparam int BW = 2 * COLS;

    logic [BW-1:0]   bank_q [2][ROWS];
    logic            front_q;
    logic            pend_q;
    logic [AW-1:0]   row_idx_q;
    logic [DW-1:0]   dwell_q;
    logic [ROWS-1:0] row_q;
    logic [COLS-1:0] colr_q;
    logic [COLS-1:0] colg_q;
    logic            tick_q;
    logic            done_q;

    logic            last_dwell;
    logic            last_row;
    logic            eof;
    logic            wr_ok;
    logic            blank;
    logic [BW-1:0]   pix;
    logic [ROWS-1:0] row_d;
    logic [COLS-1:0] colr_d;
    logic [COLS-1:0] colg_d;
    logic            pend_d;
    logic            front_d;

    assign last_dwell = (dwell_q == DW'(DWELL - 1));
    assign last_row   = (row_idx_q == AW'(ROWS - 1));
    assign eof        = last_dwell && last_row;
    assign wr_ok      = bus.wr_en && (int'(bus.wr_row) < ROWS);
    assign pix        = bank_q[front_q][row_idx_q];

    // A request arriving on the EOF edge re-arms pending even while the
    // older request is being consumed on that same edge.
    assign pend_d  = bus.swap_req || (pend_q && !eof);
    assign front_d = front_q ^ (eof && pend_q);

`ifdef DZ_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] fcnt_q;
    logic          phase_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (eof) begin
            if (!blink) begin
                fcnt_q  <= '0;
                phase_q <= 1'b0;
            end else if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    assign blank = (dwell_q == '0) || (blink && phase_q);
`else
    assign blank = (dwell_q == '0);
`endif

    always_comb begin
        row_d  = {ROWS{1'b1}};
        colr_d = '0;
        colg_d = '0;
        if (!blank) begin
            row_d  = ~(ROWS'(1) << row_idx_q);
            colr_d = pix[BW-1:COLS];
            colg_d = pix[COLS-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
            row_idx_q <= '0;
            dwell_q   <= '0;
            row_q     <= {ROWS{1'b1}};
            colr_q    <= '0;
            colg_q    <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Write goes to the bank that is back before this edge; on a
            // swap edge that bank becomes the new front.
            if (wr_ok) begin
                bank_q[~front_q][bus.wr_row[AW-1:0]] <=
                    {bus.wr_colr, bus.wr_colg};
            end
            if (last_dwell) begin
                dwell_q   <= '0;
                row_idx_q <= last_row ? '0 : row_idx_q + AW'(1);
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
            front_q <= front_d;
            pend_q  <= pend_d;
            row_q   <= row_d;
            colr_q  <= colr_d;
            colg_q  <= colg_d;
            tick_q  <= eof;
            done_q  <= eof && pend_q;
        end
    end

    assign bus.row        = row_q;
    assign bus.colr       = colr_q;
    assign bus.colg       = colg_q;
    assign bus.frame_tick = tick_q;
    assign bus.swap_done  = done_q;
    assign bus.swap_pend  = pend_q;
endmodule
